// File: rtl/matmul_pkg.sv
// Shared types and helpers for the NxN matrix-multiply engine.
package matmul_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  localparam logic WR_SEL_A = 1'b0;
  localparam logic WR_SEL_B = 1'b1;

  function automatic int unsigned idx(input int unsigned row, input int unsigned col,
                                      input int unsigned n);
    return row * n + col;
  endfunction

endpackage

// File: rtl/matmul_nxn_if.sv
// Host-side bus of the matrix-multiply engine: operand writes, start/status and C read port.
interface matmul_nxn_if #(
  parameter int unsigned N = 3,
  parameter int unsigned W = 32
);
  localparam int unsigned AW = $clog2(N * N);

  logic          wr_en;
  logic          wr_sel;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic          start;
  logic          acc_mode;
  logic          busy;
  logic          done;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data;

  modport master (
    output wr_en, wr_sel, wr_addr, wr_data, start, acc_mode, rd_addr,
    input  busy, done, rd_data
  );

  modport slave (
    input  wr_en, wr_sel, wr_addr, wr_data, start, acc_mode, rd_addr,
    output busy, done, rd_data
  );

endinterface

// File: rtl/matmul_idx_ctr.sv
// Nested i/j/k loop counter (k fastest) with wrap-around to zero after the last triple.
module matmul_idx_ctr #(
  parameter int unsigned N = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_i,
  input  logic                 clr_i,
  output logic [$clog2(N)-1:0] i_o,
  output logic [$clog2(N)-1:0] j_o,
  output logic [$clog2(N)-1:0] k_o,
  output logic                 k_last_o,
  output logic                 last_o
);
  localparam int unsigned CW = $clog2(N);
  localparam logic [CW-1:0] Max = CW'(N - 1);

  logic [CW-1:0] i_q, j_q, k_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
    end else if (en_i) begin
      if (k_q == Max) begin
        k_q <= '0;
        if (j_q == Max) begin
          j_q <= '0;
          i_q <= (i_q == Max) ? '0 : i_q + CW'(1);
        end else begin
          j_q <= j_q + CW'(1);
        end
      end else begin
        k_q <= k_q + CW'(1);
      end
    end
  end

  assign i_o      = i_q;
  assign j_o      = j_q;
  assign k_o      = k_q;
  assign k_last_o = (k_q == Max);
  assign last_o   = (i_q == Max) && (j_q == Max) && (k_q == Max);

endmodule

// File: rtl/matmul_nxn.sv
// Sequential NxN integer matrix multiply, C = A*B or C += A*B, one MAC per clock.
module matmul_nxn
  import matmul_pkg::*;
#(
  parameter int unsigned N = 3,
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  matmul_nxn_if.slave  bus
);
  localparam int unsigned AW = $clog2(N * N);
  localparam int unsigned NE = N * N;
  localparam int unsigned CW = $clog2(N);

  state_e        state_q, state_d;
  logic          mode_q;
  logic [W-1:0]  acc_q;
  logic [W-1:0]  rd_data_q;
  logic [W-1:0]  a_q [NE];
  logic [W-1:0]  b_q [NE];
  logic [W-1:0]  c_q [NE];

  logic [CW-1:0] i, j, k;
  logic          k_last, last;
  logic [AW-1:0] a_idx, b_idx, c_idx;
  logic [W-1:0]  base, prod, mac;
  logic          wr_ok, rd_ok, calc;

  assign calc = (state_q == CALC);

  matmul_idx_ctr #(.N(N)) u_ctr (
    .clk      (clk),
    .rst      (rst),
    .en_i     (calc),
    .clr_i    (!calc),
    .i_o      (i),
    .j_o      (j),
    .k_o      (k),
    .k_last_o (k_last),
    .last_o   (last)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = CALC;
      CALC:    if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign a_idx = AW'(idx(32'(i), 32'(k), N));
  assign b_idx = AW'(idx(32'(k), 32'(j), N));
  assign c_idx = AW'(idx(32'(i), 32'(j), N));

  // First term of each dot product seeds from C (accumulate) or zero.
  always_comb begin
    base = acc_q;
    if (k == '0) base = mode_q ? c_q[c_idx] : '0;
    prod = a_q[a_idx] * b_q[b_idx];
    mac  = base + prod;
  end

  assign wr_ok = bus.wr_en && (state_q == IDLE) && (32'(bus.wr_addr) < NE);
  assign rd_ok = (32'(bus.rd_addr) < NE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mode_q    <= 1'b0;
      acc_q     <= '0;
      rd_data_q <= '0;
      for (int e = 0; e < int'(NE); e++) begin
        a_q[e] <= '0;
        b_q[e] <= '0;
        c_q[e] <= '0;
      end
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && bus.start) mode_q <= bus.acc_mode;
      if (wr_ok) begin
        if (bus.wr_sel == WR_SEL_B) b_q[bus.wr_addr] <= bus.wr_data;
        else                        a_q[bus.wr_addr] <= bus.wr_data;
      end
      if (calc) begin
        if (k_last) begin
          c_q[c_idx] <= mac;
          acc_q      <= '0;
        end else begin
          acc_q <= mac;
        end
      end
      rd_data_q <= rd_ok ? c_q[bus.rd_addr] : '0;
    end
  end

  assign bus.busy    = calc;
  assign bus.done    = (state_q == DONE);
  assign bus.rd_data = rd_data_q;

endmodule
